// File: rtl/hms_clock_core_pkg.sv
// Shared mode/position codes, field widths and limits for the HH:MM:SS timekeeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hms_clock_core_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [1:0] MODE_CLOCK = 2'd0;
    localparam logic [1:0] MODE_SETUP = 2'd1;
    localparam logic [1:0] MODE_ALARM = 2'd2;

    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic {
        ALM_IDLE = 1'b0,
        ALM_RING = 1'b1
    } alm_st_t;

    // Three-state selectors (mode and position) both step 0->1->2->0.
    function automatic logic [1:0] next_sel(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

endpackage

// File: rtl/mod_cnt.sv
// Modulo counter 0..i_max advancing on en; o_wrap flags the cycle it rolls over.
// Latency: count updates one cycle after en; o_wrap is combinational.
// Backpressure: none; en is honoured every cycle.
module mod_cnt #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap
);

    assign o_wrap = en & (o_cnt == i_max);

    // Count up on enable, returning to zero after the max value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cnt <= '0;
        end else if (o_wrap) begin
            o_cnt <= '0;
        end else if (en) begin
            o_cnt <= o_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hms_clock_core.sv
// HH:MM:SS timekeeper with setup/alarm-set modes, field blink and alarm output, all on clk.
// Latency: every output is registered; pulse effects appear one cycle after the pulse.
// Backpressure: none; pulses losing the mode > pos > inc priority in a cycle are dropped.
module hms_clock_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int HOUR_MAX  = 23,
    parameter int BLINK_DIV = 12_500_000,
    parameter int ALARM_SEC = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_mode_pls,
    input  logic       i_pos_pls,
    input  logic       i_inc_pls,
    input  logic       i_alarm_en,
    input  logic       i_alarm_clr,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic [1:0] o_mode,
    output logic [1:0] o_pos,
    output logic [2:0] o_blink_mask,
    output logic       o_sec_tick,
    output logic       o_alarm
);
    import hms_clock_core_pkg::*;

    localparam int                PSC_W     = $clog2(CLK_HZ);
    localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(CLK_HZ - 1);
    localparam int                BLK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_DIV - 1);
    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX);
    localparam logic [5:0]        DUR_LAST  = 6'(ALARM_SEC - 1);

    logic [1:0]        mode, pos, mode_n, pos_n;
    logic [PSC_W-1:0]  psc;
    logic [BLK_W-1:0]  blk_cnt, blk_cnt_n;
    logic              phase, phase_n;
    logic              tick, fld_chg, inc_vld, set_inc, alm_inc;
    logic              sec_en, min_en, hour_en, sec_wrap, min_wrap, hour_wrap;
    logic [SEC_W-1:0]  sec, sec_n, alm_sec, alm_sec_n;
    logic [MIN_W-1:0]  min, min_n, alm_min, alm_min_n;
    logic [HOUR_W-1:0] hour, hour_n, alm_hour, alm_hour_n;
    logic [2:0]        mask_n;
    logic              alm_match, alm_trig, alm_expire;
    alm_st_t           alm_st;
    logic [5:0]        alm_dur;

    // Time only advances outside SETUP; a tick is the prescaler's last count.
    assign tick    = (mode != MODE_SETUP) && (psc == PSC_LAST);
    assign fld_chg = i_mode_pls | (i_pos_pls & (mode != MODE_CLOCK));
    assign inc_vld = i_inc_pls & ~i_mode_pls & ~i_pos_pls & (mode != MODE_CLOCK);
    assign set_inc = inc_vld & (mode == MODE_SETUP);
    assign alm_inc = inc_vld & (mode == MODE_ALARM);

    // Ticks carry up the chain; edits touch one field and never carry (tick and edit are exclusive).
    assign sec_en  = tick | (set_inc & (pos == POS_SEC));
    assign min_en  = (tick & sec_wrap) | (set_inc & (pos == POS_MIN));
    assign hour_en = (tick & sec_wrap & min_wrap) | (set_inc & (pos == POS_HOUR));

    mod_cnt #(.WIDTH(SEC_W)) u_sec (
        .clk(clk), .rst_n(rst_n), .en(sec_en), .i_max(SEC_MAX), .o_cnt(sec), .o_wrap(sec_wrap)
    );
    mod_cnt #(.WIDTH(MIN_W)) u_min (
        .clk(clk), .rst_n(rst_n), .en(min_en), .i_max(MIN_MAX), .o_cnt(min), .o_wrap(min_wrap)
    );
    mod_cnt #(.WIDTH(HOUR_W)) u_hour (
        .clk(clk), .rst_n(rst_n), .en(hour_en), .i_max(HOUR_LAST), .o_cnt(hour), .o_wrap(hour_wrap)
    );

    // Post-edge time values feed the registered display and the alarm comparison.
    assign sec_n  = sec_wrap  ? '0 : (sec_en  ? sec  + 1'b1 : sec);
    assign min_n  = min_wrap  ? '0 : (min_en  ? min  + 1'b1 : min);
    assign hour_n = hour_wrap ? '0 : (hour_en ? hour + 1'b1 : hour);

    // Next-state decode for mode/pos, alarm field edits, blink and mask.
    always_comb begin
        mode_n     = mode;
        pos_n      = pos;
        alm_sec_n  = alm_sec;
        alm_min_n  = alm_min;
        alm_hour_n = alm_hour;
        blk_cnt_n  = blk_cnt + 1'b1;
        phase_n    = phase;
        mask_n     = '0;
        if (i_mode_pls) begin
            mode_n = next_sel(mode);
            pos_n  = POS_SEC;
        end else if (i_pos_pls && (mode != MODE_CLOCK)) begin
            pos_n = next_sel(pos);
        end
        if (alm_inc && (pos == POS_SEC))
            alm_sec_n = (alm_sec == SEC_MAX) ? '0 : alm_sec + 1'b1;
        if (alm_inc && (pos == POS_MIN))
            alm_min_n = (alm_min == MIN_MAX) ? '0 : alm_min + 1'b1;
        if (alm_inc && (pos == POS_HOUR))
            alm_hour_n = (alm_hour == HOUR_LAST) ? '0 : alm_hour + 1'b1;
        if (fld_chg) begin
            blk_cnt_n = '0;
            phase_n   = 1'b0;
        end else if (blk_cnt == BLK_LAST) begin
            blk_cnt_n = '0;
            phase_n   = ~phase;
        end
        if (mode_n != MODE_CLOCK) begin
            case (pos_n)
                POS_SEC:  mask_n[0] = phase_n;
                POS_MIN:  mask_n[1] = phase_n;
                POS_HOUR: mask_n[2] = phase_n;
                default:  mask_n    = '0;
            endcase
        end
    end

    assign alm_match  = (sec_n == alm_sec_n) && (min_n == alm_min_n) && (hour_n == alm_hour_n);
    assign alm_trig   = tick & i_alarm_en & alm_match;
    assign alm_expire = (alm_st == ALM_RING) & tick & (alm_dur == DUR_LAST);

    // Prescaler: held at 0 in SETUP (which also covers the seconds-edit clear), wraps otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
        end else if ((mode == MODE_SETUP) || (psc == PSC_LAST)) begin
            psc <= '0;
        end else begin
            psc <= psc + 1'b1;
        end
    end

    // Control state, alarm fields, blink and the registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode         <= MODE_CLOCK;
            pos          <= POS_SEC;
            alm_sec      <= '0;
            alm_min      <= '0;
            alm_hour     <= '0;
            blk_cnt      <= '0;
            phase        <= 1'b0;
            o_sec        <= '0;
            o_min        <= '0;
            o_hour       <= '0;
            o_blink_mask <= '0;
            o_sec_tick   <= 1'b0;
        end else begin
            mode         <= mode_n;
            pos          <= pos_n;
            alm_sec      <= alm_sec_n;
            alm_min      <= alm_min_n;
            alm_hour     <= alm_hour_n;
            blk_cnt      <= blk_cnt_n;
            phase        <= phase_n;
            o_sec        <= (mode_n == MODE_ALARM) ? alm_sec_n  : sec_n;
            o_min        <= (mode_n == MODE_ALARM) ? alm_min_n  : min_n;
            o_hour       <= (mode_n == MODE_ALARM) ? alm_hour_n : hour_n;
            o_blink_mask <= mask_n;
            o_sec_tick   <= tick;
        end
    end

    assign o_mode = mode;
    assign o_pos  = pos;

    // Alarm FSM: any clear beats a trigger; a trigger (re)starts the duration count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alm_st  <= ALM_IDLE;
            alm_dur <= '0;
            o_alarm <= 1'b0;
        end else if (i_alarm_clr || !i_alarm_en || alm_expire) begin
            alm_st  <= ALM_IDLE;
            alm_dur <= '0;
            o_alarm <= 1'b0;
        end else if (alm_trig) begin
            alm_st  <= ALM_RING;
            alm_dur <= '0;
            o_alarm <= 1'b1;
        end else if ((alm_st == ALM_RING) && tick) begin
            alm_dur <= alm_dur + 1'b1;
        end
    end

endmodule

// File: tb/tb_hms_clock_core.sv
// Self-checking bench: seconds-of-day reference model compared every cycle, plus literal checks.
// Latency: model mirrors one-cycle registered outputs.
// Backpressure: n/a.
module tb_hms_clock_core;
    localparam int CLK_HZ    = 10;
    localparam int HOUR_MAX  = 23;
    localparam int BLINK_DIV = 3;
    localparam int ALARM_SEC = 3;
    localparam int DAY       = 3600 * (HOUR_MAX + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_mode_pls = 1'b0, i_pos_pls = 1'b0, i_inc_pls = 1'b0;
    logic       i_alarm_en = 1'b0, i_alarm_clr = 1'b0;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic [1:0] o_mode, o_pos;
    logic [2:0] o_blink_mask;
    logic       o_sec_tick, o_alarm;

    always #5 clk = ~clk;

    hms_clock_core #(
        .CLK_HZ(CLK_HZ), .HOUR_MAX(HOUR_MAX), .BLINK_DIV(BLINK_DIV), .ALARM_SEC(ALARM_SEC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_mode_pls(i_mode_pls), .i_pos_pls(i_pos_pls),
        .i_inc_pls(i_inc_pls), .i_alarm_en(i_alarm_en), .i_alarm_clr(i_alarm_clr),
        .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_mode(o_mode), .o_pos(o_pos),
        .o_blink_mask(o_blink_mask), .o_sec_tick(o_sec_tick), .o_alarm(o_alarm)
    );

    logic [25:0] dut_vec;
    assign dut_vec = {o_sec, o_min, o_hour, o_mode, o_pos, o_blink_mask, o_sec_tick, o_alarm};

    int checks = 0;
    int errors = 0;

    // Reference state: time and alarm as seconds-of-day, plain integers elsewhere.
    int m_mode, m_pos, m_t, m_a, m_psc, m_bc, m_ph, m_ring, m_left, m_tick;

    function automatic int bump(input int t, input int fld);
        int s, m, h;
        s = t % 60; m = (t / 60) % 60; h = t / 3600;
        if (fld == 0) s = (s + 1) % 60;
        if (fld == 1) m = (m + 1) % 60;
        if (fld == 2) h = (h + 1) % (HOUR_MAX + 1);
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_t = 0; m_a = 0; m_psc = 0;
        m_bc = 0; m_ph = 0; m_ring = 0; m_left = 0; m_tick = 0;
    endtask

    task automatic model_step();
        int nm, np;
        bit chg, inc, tk, trig, clr;
        tk = (m_mode != 1) && (m_psc == CLK_HZ - 1);
        nm = m_mode; np = m_pos; chg = 0;
        if (i_mode_pls) begin
            nm = (m_mode + 1) % 3; np = 0; chg = 1;
        end else if (i_pos_pls && m_mode != 0) begin
            np = (m_pos + 1) % 3; chg = 1;
        end
        inc = i_inc_pls && !i_mode_pls && !i_pos_pls && m_mode != 0;
        if (tk) m_t = (m_t + 1) % DAY;
        if (inc && m_mode == 1) m_t = bump(m_t, m_pos);
        if (inc && m_mode == 2) m_a = bump(m_a, m_pos);
        m_psc = (m_mode == 1) ? 0 : (m_psc + 1) % CLK_HZ;
        if (chg) begin
            m_bc = 0; m_ph = 0;
        end else begin
            m_bc = m_bc + 1;
            if (m_bc == BLINK_DIV) begin m_bc = 0; m_ph = 1 - m_ph; end
        end
        trig = tk && i_alarm_en && (m_t == m_a);
        clr  = i_alarm_clr || !i_alarm_en || (m_ring == 1 && tk && m_left == 1);
        if (clr) m_ring = 0;
        else if (trig) begin m_ring = 1; m_left = ALARM_SEC; end
        else if (m_ring == 1 && tk) m_left = m_left - 1;
        m_mode = nm; m_pos = np; m_tick = tk ? 1 : 0;
    endtask

    function automatic logic [25:0] model_vec();
        int d;
        logic [2:0] mk;
        d  = (m_mode == 2) ? m_a : m_t;
        mk = (m_mode == 0) ? 3'b000 : 3'(m_ph << m_pos);
        return {6'(d % 60), 6'((d / 60) % 60), 5'(d / 3600), 2'(m_mode), 2'(m_pos),
                mk, 1'(m_tick), 1'(m_ring)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL model_cmp t=%0t dut=%h expected=%h", $time, dut_vec, model_vec());
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic mp, input logic pp, input logic ip, input logic cl);
        i_mode_pls = mp; i_pos_pls = pp; i_inc_pls = ip; i_alarm_clr = cl;
        @(negedge clk);
        i_mode_pls = 0; i_pos_pls = 0; i_inc_pls = 0; i_alarm_clr = 0;
    endtask

    task automatic wait_alarm(input logic lvl, input int budget);
        int w;
        w = 0;
        while (o_alarm !== lvl && w < budget) begin
            step(0, 0, 0, 0);
            w++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int tk[$];
        int nt;
        repeat (3) @(negedge clk);
        check("reset_state", int'(dut_vec), 0);
        rst_n = 1'b1;

        // 1: free run from reset
        for (int i = 1; i <= 25; i++) begin
            step(0, 0, 0, 0);
            if (o_sec_tick) tk.push_back(i);
        end
        check("t1_tick_count", tk.size(), 2);
        check("t1_tick0", (tk.size() > 0) ? tk[0] : -1, 10);
        check("t1_tick1", (tk.size() > 1) ? tk[1] : -1, 20);
        check("t1_sec", o_sec, 2);
        check("t1_min_hour", {o_min, o_hour}, 0);

        // 2: set 23:59:59, back to CLOCK, roll over
        step(1, 0, 0, 0);
        repeat (57) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        repeat (59) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        repeat (23) step(0, 0, 1, 0);
        check("t2_set_hms", o_hour * 3600 + o_min * 60 + o_sec, 23 * 3600 + 59 * 60 + 59);
        step(1, 0, 0, 0);
        nt = 0;
        step(1, 0, 0, 0);
        if (o_sec_tick) nt++;
        repeat (9) begin
            step(0, 0, 0, 0);
            if (o_sec_tick) nt++;
        end
        check("t2_single_tick", nt, 1);
        check("t2_rollover", o_hour * 3600 + o_min * 60 + o_sec, 0);

        // 3: seconds edit wraps without carry; time frozen in SETUP
        step(1, 0, 0, 0);
        repeat (59) step(0, 0, 1, 0);
        check("t3_sec59", o_sec, 59);
        step(0, 0, 1, 0);
        check("t3_sec_wrap", o_sec, 0);
        check("t3_min_nocarry", o_min, 0);
        nt = 0;
        repeat (50) begin
            step(0, 0, 0, 0);
            if (o_sec_tick) nt++;
        end
        check("t3_no_tick", nt, 0);

        // 4: alarm 00:00:02, expiry after ALARM_SEC ticks, then clear by pulse
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 1, 0);
        i_alarm_en = 1'b1;
        step(1, 0, 0, 0);
        wait_alarm(1'b1, 40);
        check("t4_rise", o_alarm, 1);
        check("t4_rise_sec", o_sec, 2);
        wait_alarm(1'b0, 50);
        check("t4_fall", o_alarm, 0);
        check("t4_fall_sec", o_sec, 5);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (5) step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        wait_alarm(1'b1, 40);
        check("t4_rise2_sec", o_sec, 7);
        check("t4_rise2", o_alarm, 1);
        step(0, 0, 0, 1);
        check("t4_clr", o_alarm, 0);

        // 5: priority mode > pos > inc; blink phase after pos change
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("t5_mode_wins", o_mode, 2);
        check("t5_alarm_sec", o_sec, 7);
        step(0, 1, 1, 0);
        check("t5_pos_wins", o_pos, 1);
        check("t5_field_kept", {o_min, o_hour}, 0);
        check("t5_mask_cleared", o_blink_mask, 0);
        repeat (3) step(0, 0, 0, 0);
        check("t5_mask_min", o_blink_mask, 3'b010);

        // random soak against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) i_alarm_en = ~i_alarm_en;
            step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 2);
        end

        // 6: asynchronous reset while ringing in ALARM mode
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        i_alarm_en = 1'b1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        wait_alarm(1'b1, 30);
        check("t6_ringing", {o_mode, o_alarm}, {2'd2, 1'b1});
        #2 rst_n = 1'b0;
        #1 check("t6_async_reset", int'(dut_vec), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
